// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// default bus widths and the flattened-bus slicing helper.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Low bit of requester idx's field inside a flattened per-requester bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the arbiter, bundled.
// slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int DATA_W  = mem_arb_pkg::DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      mem_wr_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic [DATA_W-1:0]         mem_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_wr_en, mem_addr, mem_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_wr_en, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Search upward from the requester after the previous winner.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      cand = int'(last_grant) + k;
      cand = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
      if (!any_grant && req[cand]) begin
        any_grant      = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = IDX_W'(cand);
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory among NUM_REQ requesters: round-robin grant,
// one transaction in flight, MEM_LATENCY-cycle access, one-cycle response pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = mem_arb_pkg::ADDR_W,
  parameter int DATA_W      = mem_arb_pkg::DATA_W,
  parameter int MEM_LATENCY = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] RESP = ST_RESP;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .any_grant  (arb_any)
  );

  // Next-state, counter and transaction latches.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          we_d    = bus.req_we[arb_idx];
          addr_d  = bus.req_addr[slice_lo(int'(arb_idx), ADDR_W) +: ADDR_W];
          wdata_d = bus.req_wdata[slice_lo(int'(arb_idx), DATA_W) +: DATA_W];
          grant_d = arb_idx;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Writes echo their data so rsp_rdata is always meaningful.
          rdata_d = we_q ? wdata_q : bus.mem_data_out;
          state_d = RESP;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Handshake, response pulse and write strobe decode.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (!rst && (state_q == IDLE)) begin
      bus.req_ready = arb_oh;
    end else begin
      bus.req_ready = '0;
    end
    if (state_q == RESP) begin
      bus.rsp_valid[grant_q] = 1'b1;
    end else begin
      bus.rsp_valid = '0;
    end
    bus.mem_wr_en = (state_q == BUSY) && (cnt_q == CNT_ZERO) && we_q;
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = wdata_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a timestamp-based transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // Backing memories: a small array for dut, an address-derived pattern for dut1.
  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  assign bus.mem_data_out  = env_mem[bus.mem_addr[7:0]];
  assign bus1.mem_data_out = {bus1.mem_addr[15:0], 16'hA5A5};

  always @(posedge clk) begin
    if (bus.mem_wr_en) env_mem[bus.mem_addr[7:0]] <= bus.mem_data;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: one transaction at a time, described by the cycle it was accepted.
  int          last_g, exp_g, resp_at, wr_at, pick;
  logic        exp_we, e_wr;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [N-1:0] e_ready, e_rsp;
  int          grant_log [$];
  int          rsp_cyc [N];
  int          rsp_n [N];
  logic [31:0] rsp_dat;
  int          wr_cnt = 0;
  logic [31:0] wr_addr;

  always @(negedge clk) begin
    if (rst) begin
      last_g = N - 1; exp_g = 0; resp_at = -1; wr_at = -1; exp_we = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    end else begin
      pick = -1;
      e_ready = '0;
      if (cyc > resp_at) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (last_g + k) % N;
          if (pick < 0 && bus.req_valid[i]) pick = i;
        end
      end
      if (pick >= 0) e_ready[pick] = 1'b1;
      e_wr  = (cyc == wr_at) && exp_we;
      e_rsp = '0;
      if (cyc == resp_at) begin
        e_rsp[exp_g] = 1'b1;
        exp_rdata = exp_we ? exp_wdata : ref_mem[exp_addr[7:0]];
      end
      chk("req_ready", 64'(bus.req_ready), 64'(e_ready));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
      chk("mem_wr_en", 64'(bus.mem_wr_en), 64'(e_wr));
      chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
      chk("mem_data", 64'(bus.mem_data), 64'(exp_wdata));
      if (e_wr) ref_mem[exp_addr[7:0]] = exp_wdata;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] && bus.req_valid[i]) grant_log.push_back(i);
        if (bus.rsp_valid[i]) begin
          rsp_cyc[i] = cyc; rsp_n[i]++; rsp_dat = bus.rsp_rdata;
        end
      end
      if (bus.mem_wr_en) begin
        wr_cnt++; wr_addr = bus.mem_addr;
      end
      if (pick >= 0) begin
        exp_g     = pick;
        exp_we    = bus.req_we[pick];
        exp_addr  = bus.req_addr[pick*AW +: AW];
        exp_wdata = bus.req_wdata[pick*DW +: DW];
        wr_at     = cyc + LAT;
        resp_at   = cyc + LAT + 1;
        last_g    = pick;
      end
    end
    cyc++;
  end

  // Event log of the MEM_LATENCY=1 instance.
  int          b_cyc = 0;
  int          b_acc [$];
  int          b_rsp [$];
  logic [31:0] b_dat [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.req_ready[0] && bus1.req_valid[0]) b_acc.push_back(b_cyc);
      if (bus1.rsp_valid[0]) begin
        b_rsp.push_back(b_cyc); b_dat.push_back(bus1.rsp_rdata);
      end
    end
    b_cyc++;
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;  bus.req_we = '0;  bus.req_addr = '0;  bus.req_wdata = '0;
    bus1.req_valid = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.req_we[i] = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
    bus.req_valid[i] = 1'b1;
  endtask

  // Presents one request (called just after a posedge) and returns its accept cycle.
  task automatic do_txn(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int acc);
    set_req(i, we, a, d);
    acc = -1;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready[i]) acc = cyc - 1;
      @(posedge clk);
      #1;
    end
    bus.req_valid[i] = 1'b0;
    chk("txn_accepted", 64'(acc >= 0), 64'd1);
  endtask

  int acc, acc2, c0, base, n0, w0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    env_mem[8'h10] = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hDEAD_BEEF;
    do_reset();

    // Single read by r0 straight out of reset.
    c0 = cyc;
    do_txn(0, 1'b0, 32'h10, 32'h0, acc);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("t1_accept_cycle", 64'(acc - c0), 64'd0);
    chk("t1_rsp_latency", 64'(rsp_cyc[0] - acc), 64'd5);
    chk("t1_rdata", 64'(rsp_dat), 64'hDEAD_BEEF);
    chk("t1_no_write", 64'(wr_cnt), 64'd0);

    // r1 writes then reads back.
    w0 = wr_cnt;
    do_txn(1, 1'b1, 32'h20, 32'hCAFE_F00D, acc);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("t2_write_once", 64'(wr_cnt - w0), 64'd1);
    chk("t2_write_addr", 64'(wr_addr), 64'h20);
    chk("t2_mem_content", 64'(env_mem[8'h20]), 64'hCAFE_F00D);
    do_txn(1, 1'b0, 32'h20, 32'h0, acc);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("t2_read_latency", 64'(rsp_cyc[1] - acc), 64'd5);
    chk("t2_read_data", 64'(rsp_dat), 64'hCAFE_F00D);

    // Both requesters held continuously: strict alternation starting at r0.
    do_reset();
    base = grant_log.size();
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h20, 32'h0);
    for (int n = 0; n < 100 && grant_log.size() < base + 8; n++) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    chk("t3_eight_grants", 64'(grant_log.size() >= base + 8), 64'd1);
    if (grant_log.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) chk("t3_grant_order", 64'(grant_log[base+k]), 64'(k % 2));
    end

    // MEM_LATENCY=1 instance: back-to-back reads from r0.
    bus1.req_we[0] = 1'b0;
    bus1.req_addr[0 +: AW] = 32'h44;
    bus1.req_valid[0] = 1'b1;
    for (int n = 0; n < 40 && b_rsp.size() < 3; n++) begin
      @(posedge clk);
      #1;
    end
    bus1.req_valid[0] = 1'b0;
    chk("t4_three_rsp", 64'(b_rsp.size() >= 3 && b_acc.size() >= 3), 64'd1);
    if (b_rsp.size() >= 3 && b_acc.size() >= 3) begin
      chk("t4_accept_spacing_a", 64'(b_acc[1] - b_acc[0]), 64'd3);
      chk("t4_accept_spacing_b", 64'(b_acc[2] - b_acc[1]), 64'd3);
      for (int k = 0; k < 3; k++) chk("t4_rsp_latency", 64'(b_rsp[k] - b_acc[k]), 64'd2);
      chk("t4_rdata", 64'(b_dat[0]), 64'h0044_A5A5);
    end

    // Reset in the middle of a write: nothing lands, nothing responds.
    repeat (2) @(posedge clk);
    #1;
    n0 = rsp_n[1];
    w0 = wr_cnt;
    do_txn(1, 1'b1, 32'h30, 32'h1111_2222, acc);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("t5_mem_untouched", 64'(env_mem[8'h30]), 64'd0);
    chk("t5_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t5_no_rsp", 64'(rsp_n[1] - n0), 64'd0);
    base = grant_log.size();
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h20, 32'h0);
    for (int n = 0; n < 40 && grant_log.size() < base + 2; n++) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    chk("t5_two_grants", 64'(grant_log.size() >= base + 2), 64'd1);
    if (grant_log.size() >= base + 2) begin
      chk("t5_first_grant", 64'(grant_log[base]), 64'd0);
      chk("t5_second_grant", 64'(grant_log[base+1]), 64'd1);
    end

    // r0 withdraws its request while r1 is being served.
    repeat (LAT + 3) @(posedge clk);
    #1;
    do_txn(1, 1'b0, 32'h10, 32'h0, acc);
    base = grant_log.size();
    set_req(0, 1'b0, 32'h20, 32'h0);
    repeat (2) @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("t6_no_r0_grant", 64'(grant_log.size() - base), 64'd0);
    chk("t6_idle_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    c0 = cyc;
    do_txn(1, 1'b0, 32'h20, 32'h0, acc2);
    chk("t6_immediate_accept", 64'(acc2 - c0), 64'd0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("t6_rdata", 64'(rsp_dat), 64'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port word memory between NUM_REQ requesters, e.g. I-cache refill and D-cache refill/writeback.
- Per-requester valid/ready request handshake; round-robin arbitration; one transaction in flight.
- Configurable access-latency counter emulates slow backing store.
- Drives the memory's wr_en/addr/data and samples its combinational read port; returns a one-cycle response pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_W, 32, memory address width.
- DATA_W, 32, data word width.
- MEM_LATENCY, 4, cycles spent in BUSY per access (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_we  input  NUM_REQ  per-requester write (1) / read (0).
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data, same packing.
- rsp_valid  output  NUM_REQ  one-hot response pulse to the granted requester.
- rsp_rdata  output  DATA_W  read data, qualified by rsp_valid.
- mem_wr_en  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_data  output  DATA_W  memory write data.
- mem_data_out  input  DATA_W  memory combinational read data.

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset values (asynchronous, effective immediately):
  - state=IDLE.
  - Latched we/addr/wdata/grant = 0; cnt=0; rdata reg=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0.
- IDLE:
  - req_ready is combinational. If any req_valid, grant g = first valid index searching upward from last_grant+1, modulo NUM_REQ.
  - req_ready[g]=1 that cycle; a handshake completes when valid and ready are both high.
  - On the edge: latch we/addr/wdata/g, set cnt=MEM_LATENCY-1, go to BUSY.
  - No valid: stay in IDLE, req_ready=0.
- BUSY:
  - req_ready=0 for all requesters.
  - mem_addr = latched addr; mem_data = latched wdata.
  - cnt!=0: decrement, mem_wr_en=0.
  - cnt==0, write: mem_wr_en=1 for exactly this cycle.
  - cnt==0, read: capture mem_data_out into the rdata reg.
  - Either case: go to RESP.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle.
  - rsp_rdata = captured read data on a read; latched wdata on a write.
  - last_grant <= grant; go to IDLE.
- Latency: accept cycle, plus MEM_LATENCY BUSY cycles, then RESP. rsp_valid rises MEM_LATENCY+1 cycles after the accepting edge. Peak throughput is one transaction per MEM_LATENCY+2 cycles.
- Stability outside BUSY:
  - mem_addr/mem_data hold the last latched values.
  - mem_wr_en=0.
  - rsp_rdata holds its value between responses.
- No response backpressure; requesters must accept rsp_valid whenever it is asserted.
- Requesters hold req_valid and payload stable until ready. Dropping valid before ready is legal: the request is withdrawn and no transaction occurs.
- A requester may re-request in the RESP cycle. It is considered in the next IDLE with the updated rotation.
- MEM_LATENCY=1: BUSY lasts one cycle, with cnt==0 on entry.
- Reset in BUSY or RESP aborts the transaction: no mem write, no rsp_valid, rotation restarts at requester 0.
- Addresses are passed through unchecked; range checking is the memory's responsibility.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - Default width constants ADDR_W and DATA_W.
  - Helper function for the flattened-bus slice index.
- Sub-module rr_arbiter:
  - Combinational round-robin pick.
  - Inputs: req vector and last_grant. Outputs: one-hot grant, grant index, any_grant.
- The FSM, counter and latches live in mem_arbiter.

Test Plan:
- Single read, MEM_LATENCY=4, mem preloaded [0x10]=0xDEADBEEF: r0 read 0x10 -> req_ready[0] in cycle 0; rsp_valid[0] at cycle 5; rsp_rdata=0xDEADBEEF; mem_wr_en never 1.
- Write then read: r1 writes 0xCAFEF00D to 0x20, then reads 0x20 -> mem_wr_en high exactly one cycle with addr 0x20; read response 0xCAFEF00D.
- Simultaneous r0/r1 reads after reset -> r0 granted first, r1 next. Both held continuously -> grants alternate 0,1,0,1 over 8 transactions.
- MEM_LATENCY=1: back-to-back reads from r0 -> rsp_valid 2 cycles after each accept; a new accept every 3 cycles.
- Reset asserted mid-BUSY of an r1 write to 0x30 -> mem[0x30] unchanged; no rsp_valid. After reset, simultaneous requests grant r0 first.
- r0 drops req_valid while r1 is being served -> no grant to r0; state returns to IDLE with all req_ready=0.
